parking_occupancy: RTL and testbench

//   Upstream of the Full LED stage. Arbitrates entry/exit gate requests.

---
 rtl/parking_occupancy_pkg.sv | 20 ++
 rtl/parking_occupancy_gate_timer.sv | 29 ++
 rtl/parking_occupancy.sv | 129 ++++++++++++
 tb/tb_parking_occupancy.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_occupancy_pkg.sv
// Shared definitions for the parking occupancy block: gate FSM state
// encodings and the default lot parameters used by the Full stage and top level.
package parking_occupancy_pkg;

    // Gate FSM states; encodings are fixed so downstream stages can decode them.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StEntryOpen = 2'd1,
        StExitOpen  = 2'd2
    } gate_state_e;

    localparam int unsigned DefaultCapacity    = 4;
    localparam int unsigned DefaultGateTimeout = 10;

    // Width needed to hold a car count in the range 0..capacity.
    function automatic int unsigned count_width(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/parking_occupancy_gate_timer.sv
// Gate-open timer: counts cycles while run is high, cleared by clear.
// done is high for the cycle in which the count sits at LIMIT-1.
module parking_occupancy_gate_timer #(
    parameter int unsigned LIMIT = 10
) (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam int unsigned TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [TW-1:0] LastCount = TW'(LIMIT - 1);

    logic [TW-1:0] cnt_q;

    // Cycle counter; saturates at LIMIT-1 so a stalled gate never wraps the timer.
    always_ff @(posedge clk_1Hz) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != LastCount)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done = (cnt_q == LastCount);

endmodule

// File: rtl/parking_occupancy.sv
// Parking occupancy controller: arbitrates entry/exit gate requests, runs the
// gate-open FSM with pass-sensor handshake and timeout, tracks parked cars and
// emits a one-cycle full_signal pulse for the downstream Full LED stage.
module parking_occupancy
    import parking_occupancy_pkg::*;
#(
    parameter int unsigned CAPACITY     = DefaultCapacity,
    parameter int unsigned GATE_TIMEOUT = DefaultGateTimeout,
    localparam int unsigned CW          = count_width(CAPACITY)
) (
    input  logic          clk_1Hz,
    input  logic          reset,
    input  logic          entry_req,
    input  logic          exit_req,
    input  logic          entry_pass,
    input  logic          exit_pass,
    output logic          gate_open_in,
    output logic          gate_open_out,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free_spaces,
    output logic          full_signal,
    output logic          full_level,
    output logic          empty,
    output logic          timeout_pulse
);

    localparam logic [CW-1:0] CapCount = CW'(CAPACITY);

    gate_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_signal_q, full_signal_d;
    logic          timeout_q, timeout_d;
    logic          inc, dec;
    logic          timer_clear, timer_run, timer_done;

    // Timer held at zero while idle, so every gate opening starts a fresh count.
    assign timer_clear = (state_q == StIdle);
    assign timer_run   = (state_q != StIdle);

    parking_occupancy_gate_timer #(
        .LIMIT (GATE_TIMEOUT)
    ) u_gate_timer (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .clear   (timer_clear),
        .run     (timer_run),
        .done    (timer_done)
    );

    // FSM next state: exit has priority; a pass beats a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        inc       = 1'b0;
        dec       = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (exit_req && (count_q != '0)) begin
                    state_d = StExitOpen;
                end else if (entry_req && (count_q != CapCount)) begin
                    state_d = StEntryOpen;
                end
            end
            StEntryOpen: begin
                if (entry_pass) begin
                    inc     = 1'b1;
                    state_d = StIdle;
                end else if (timer_done) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StExitOpen: begin
                if (exit_pass) begin
                    dec     = 1'b1;
                    state_d = StIdle;
                end else if (timer_done) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Count next value; the bounds guards are redundant with the FSM but keep it wrap-free.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CapCount)) begin
            count_d = count_q + 1'b1;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Full pulse fires only on the transition into the full count.
    always_comb begin
        full_signal_d = (count_d == CapCount) && (count_q != CapCount);
    end

    // State, count and pulse registers.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            full_signal_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            full_signal_q <= full_signal_d;
            timeout_q     <= timeout_d;
        end
    end

    // The FSM must never ask to move the count past its limits.
    count_bounds_a: assert property (@(posedge clk_1Hz) disable iff (reset)
        !(inc && (count_q == CapCount)) && !(dec && (count_q == '0)));

    assign gate_open_in  = (state_q == StEntryOpen);
    assign gate_open_out = (state_q == StExitOpen);
    assign count         = count_q;
    assign free_spaces   = CapCount - count_q;
    assign full_level    = (count_q == CapCount);
    assign empty         = (count_q == '0);
    assign full_signal   = full_signal_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_parking_occupancy.sv
// Bench for parking_occupancy: directed scenarios, an event-level model of the
// lot checked every cycle, plus hand-computed literal expectations.
module tb_parking_occupancy;

    localparam int CAP = 4;
    localparam int TMO = 10;

    logic       clk_1Hz = 1'b0;
    logic       reset = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       entry_pass = 1'b0;
    logic       exit_pass = 1'b0;
    logic       gate_open_in, gate_open_out;
    logic [2:0] count, free_spaces;
    logic       full_signal, full_level, empty, timeout_pulse;

    int errors = 0;
    int checks = 0;
    int full_pulses = 0;
    bit checking = 1'b0;

    // Model: which gate is open (0 none, 1 entry, 2 exit), cars parked,
    // how many cycles the current gate has been open, and the two pulses.
    int m_cars = 0;
    int m_gate = 0;
    int m_open = 0;
    bit m_full = 1'b0;
    bit m_tout = 1'b0;

    parking_occupancy #(
        .CAPACITY     (CAP),
        .GATE_TIMEOUT (TMO)
    ) dut (
        .clk_1Hz       (clk_1Hz),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .entry_pass    (entry_pass),
        .exit_pass     (exit_pass),
        .gate_open_in  (gate_open_in),
        .gate_open_out (gate_open_out),
        .count         (count),
        .free_spaces   (free_spaces),
        .full_signal   (full_signal),
        .full_level    (full_level),
        .empty         (empty),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1Hz);
        #1;
    endtask

    // Lot behaviour per clock: a car crossing an open gate moves the count,
    // an unattended gate gives up after TMO open cycles.
    always @(posedge clk_1Hz) begin
        int ncars, ngate, nopen;
        bit tout;
        if (reset) begin
            m_cars <= 0;
            m_gate <= 0;
            m_open <= 0;
            m_full <= 1'b0;
            m_tout <= 1'b0;
        end else begin
            ncars = m_cars;
            ngate = m_gate;
            nopen = m_open;
            tout  = 1'b0;
            if (m_gate == 0) begin
                if (exit_req && m_cars > 0) begin
                    ngate = 2;
                    nopen = 1;
                end else if (entry_req && m_cars < CAP) begin
                    ngate = 1;
                    nopen = 1;
                end
            end else begin
                if ((m_gate == 1 && entry_pass) || (m_gate == 2 && exit_pass)) begin
                    ncars = (m_gate == 1) ? m_cars + 1 : m_cars - 1;
                    ngate = 0;
                end else if (m_open == TMO) begin
                    ngate = 0;
                    tout  = 1'b1;
                end else begin
                    nopen = m_open + 1;
                end
            end
            m_cars <= ncars;
            m_gate <= ngate;
            m_open <= nopen;
            m_full <= (ncars == CAP) && (m_cars != CAP);
            m_tout <= tout;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_1Hz) begin
        if (checking) begin
            chk("gate_open_in", int'(gate_open_in), int'(m_gate == 1));
            chk("gate_open_out", int'(gate_open_out), int'(m_gate == 2));
            chk("count", int'(count), m_cars);
            chk("free_spaces", int'(free_spaces), CAP - m_cars);
            chk("full_level", int'(full_level), int'(m_cars == CAP));
            chk("empty", int'(empty), int'(m_cars == 0));
            chk("full_signal", int'(full_signal), int'(m_full));
            chk("timeout_pulse", int'(timeout_pulse), int'(m_tout));
            if (full_signal) full_pulses <= full_pulses + 1;
        end
    end

    task automatic do_entry();
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        tick(1);
        entry_pass = 1'b1;
        tick(1);
        entry_pass = 1'b0;
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        tick(1);
        exit_req = 1'b0;
        exit_pass = 1'b1;
        tick(1);
        exit_pass = 1'b0;
    endtask

    initial begin
        // 1. Reset for two cycles.
        tick(1);
        checking = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_free", int'(free_spaces), 4);
        chk("rst_gates", int'({gate_open_in, gate_open_out}), 0);
        chk("rst_full", int'(full_signal), 0);

        // 2. Fill the lot; pass arrives two cycles after the request.
        for (int i = 0; i < 4; i++) begin
            entry_req = 1'b1;
            tick(1);
            chk("fill_gate_in", int'(gate_open_in), 1);
            entry_req = 1'b0;
            tick(1);
            entry_pass = 1'b1;
            tick(1);
            entry_pass = 1'b0;
            chk("fill_count", int'(count), i + 1);
            chk("fill_full_sig", int'(full_signal), int'(i == 3));
        end
        chk("fill_full_level", int'(full_level), 1);

        // 3. Entry request while full is refused.
        entry_req = 1'b1;
        tick(5);
        chk("full_gate_in", int'(gate_open_in), 0);
        chk("full_count", int'(count), 4);
        entry_req = 1'b0;
        tick(1);
        chk("full_pulses_once", full_pulses, 1);

        // Leave and return: full_signal fires again.
        do_exit();
        chk("refill_free", int'(free_spaces), 1);
        do_entry();
        chk("refill_full_sig", int'(full_signal), 1);
        do_exit();
        do_exit();
        chk("pre4_count", int'(count), 2);
        tick(1);
        chk("full_pulses_twice", full_pulses, 2);

        // 4. Simultaneous requests: exit served first, entry_pass ignored meanwhile.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick(1);
        chk("both_exit_first", int'(gate_open_out), 1);
        chk("both_entry_wait", int'(gate_open_in), 0);
        exit_req   = 1'b0;
        exit_pass  = 1'b1;
        entry_pass = 1'b1;
        tick(1);
        exit_pass  = 1'b0;
        entry_pass = 1'b0;
        chk("both_after_exit", int'(count), 1);
        tick(1);
        chk("both_entry_next", int'(gate_open_in), 1);
        entry_req  = 1'b0;
        entry_pass = 1'b1;
        tick(1);
        entry_pass = 1'b0;
        chk("both_after_entry", int'(count), 2);

        // 5. Entry with no pass times out after the 10th open cycle.
        do_exit();
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        tick(9);
        chk("tmo_still_open", int'(gate_open_in), 1);
        chk("tmo_no_pulse_yet", int'(timeout_pulse), 0);
        tick(1);
        chk("tmo_closed", int'(gate_open_in), 0);
        chk("tmo_pulse", int'(timeout_pulse), 1);
        chk("tmo_count", int'(count), 1);
        tick(1);
        chk("tmo_pulse_once", int'(timeout_pulse), 0);

        // 6. Reset while the exit gate is open at count 3.
        do_entry();
        do_entry();
        chk("pre6_count", int'(count), 3);
        exit_req = 1'b1;
        tick(1);
        exit_req = 1'b0;
        chk("pre6_gate_out", int'(gate_open_out), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_gate", int'(gate_open_out), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        exit_pass = 1'b1;
        tick(1);
        exit_pass = 1'b0;
        chk("stale_pass_count", int'(count), 0);
        exit_req = 1'b1;
        tick(3);
        exit_req = 1'b0;
        chk("empty_exit_refused", int'(gate_open_out), 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
